// File: rtl/fetch_if.sv
// Fetch-side bus of the pipelined core. The sequencer uses the master modport.
// The slave modport is for the memory/EX/hazard/decode side.
interface fetch_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_in;
  logic               freeze;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc1;
  logic [15:0]        fetch_cnt;

  modport master (
    output pc_out, id_valid, id_instr, id_pc1, fetch_cnt,
    input  instr_in, freeze, br_taken, br_target, id_ready
  );

  modport slave (
    input  pc_out, id_valid, id_instr, id_pc1, fetch_cnt,
    output instr_in, freeze, br_taken, br_target, id_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Owns the PC, fetches from a combinational instruction memory into a 2-entry FIFO.
// The FIFO feeds decode over valid/ready and honours branch redirects and freezes.
//
// state  | meaning
// BOOT   | first cycle after reset; no fetch, no pop, redirects ignored
// RUN    | fetching one instruction per cycle while the queue has room
// FROZEN | PC held, no fetch; decode may still drain the queue
module fetch_sequencer #(
  parameter int                  PC_W     = 16,
  parameter int                  INSTR_W  = 16,
  parameter logic [PC_W-1:0]     PC_RESET = '0,
  parameter logic [INSTR_W-1:0]  NOP      = '0
) (
  input  logic      clk,
  input  logic      rst,
  fetch_if.master   bus
);

  typedef enum logic [1:0] {BOOT, RUN, FROZEN} state_t;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_inc;
  logic [1:0]         count;
  logic [INSTR_W-1:0] q_instr [2];
  logic [PC_W-1:0]    q_pc1   [2];
  logic [15:0]        fetch_cnt;
  logic               redirect;
  logic               pop;
  logic               push;

  assign pc_inc = pc + 1'b1;

  always_comb begin
    state_nxt = state;
    redirect  = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    case (state)
      BOOT: state_nxt = bus.freeze ? FROZEN : RUN;
      RUN, FROZEN: begin
        // A redirect wins over everything: the head stays unconsumed and is flushed.
        redirect  = bus.br_taken;
        pop       = (count != 2'd0) && bus.id_ready && !bus.br_taken;
        push      = (state == RUN) && !bus.freeze && !bus.br_taken
                    && ((count < 2'd2) || pop);
        state_nxt = bus.freeze ? FROZEN : RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= PC_RESET;
      count      <= 2'd0;
      fetch_cnt  <= 16'd0;
      q_instr[0] <= NOP;
      q_instr[1] <= NOP;
      q_pc1[0]   <= '0;
      q_pc1[1]   <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        pc    <= bus.br_target;
        count <= 2'd0;
      end else begin
        if (push) begin
          pc <= pc_inc;
          if (fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
        end
        case ({push, pop})
          2'b10: begin
            count <= count + 2'd1;
            if (count == 2'd0) begin
              q_instr[0] <= bus.instr_in;
              q_pc1[0]   <= pc_inc;
            end else begin
              q_instr[1] <= bus.instr_in;
              q_pc1[1]   <= pc_inc;
            end
          end
          2'b01: begin
            count      <= count - 2'd1;
            q_instr[0] <= q_instr[1];
            q_pc1[0]   <= q_pc1[1];
          end
          2'b11: begin
            // Count unchanged; the new entry lands behind whatever survives the pop.
            if (count == 2'd1) begin
              q_instr[0] <= bus.instr_in;
              q_pc1[0]   <= pc_inc;
            end else begin
              q_instr[0] <= q_instr[1];
              q_pc1[0]   <= q_pc1[1];
              q_instr[1] <= bus.instr_in;
              q_pc1[1]   <= pc_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.pc_out    = pc;
  assign bus.id_valid  = (count != 2'd0);
  assign bus.id_instr  = (count != 2'd0) ? q_instr[0] : NOP;
  assign bus.id_pc1    = (count != 2'd0) ? q_pc1[0]   : '0;
  assign bus.fetch_cnt = fetch_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based reference model.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if bus  ();
  fetch_if wbus ();

  logic [15:0] mem [0:65535];

  assign bus.instr_in  = mem[bus.pc_out];
  assign wbus.instr_in = mem[wbus.pc_out];

  fetch_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_sequencer #(.PC_RESET(16'hFFFF)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc1;
  } entry_t;

  entry_t      mq [$];
  logic [15:0] m_pc;
  logic [15:0] m_cnt;
  bit          m_boot;
  bit          m_frozen;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    entry_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    check_val({tag, "_valid"}, 32'(bus.id_valid),  32'(mq.size() != 0));
    check_val({tag, "_instr"}, 32'(bus.id_instr),  32'(h.instr));
    check_val({tag, "_pc1"},   32'(bus.id_pc1),    32'(h.pc1));
    check_val({tag, "_pc"},    32'(bus.pc_out),    32'(m_pc));
    check_val({tag, "_cnt"},   32'(bus.fetch_cnt), 32'(m_cnt));
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc     = 16'd0;
    m_cnt    = 16'd0;
    m_boot   = 1'b1;
    m_frozen = 1'b0;
  endtask

  // One clock: apply inputs, advance the model by the fetch rules, then compare.
  task automatic step(input bit fz, input bit br, input logic [15:0] tgt, input bit rdy);
    bit pop, push;
    bus.freeze    = fz;
    bus.br_taken  = br;
    bus.br_target = tgt;
    bus.id_ready  = rdy;
    if (m_boot) begin
      m_boot   = 1'b0;
      m_frozen = fz;
    end else if (br) begin
      mq.delete();
      m_pc     = tgt;
      m_frozen = fz;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      push = !m_frozen && !fz && ((mq.size() < 2) || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back({mem[m_pc], 16'(m_pc + 16'd1)});
        m_pc = m_pc + 16'd1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      m_frozen = fz;
    end
    @(posedge clk);
    #1;
    check_model("cyc");
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.freeze    = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = 16'd0;
    bus.id_ready  = 1'b0;
    #1;
    check_val("rst_valid", 32'(bus.id_valid), 32'h0);
    check_val("rst_pc",    32'(bus.pc_out),   32'h0);
    check_val("rst_instr", 32'(bus.id_instr), 32'h0);
    check_val("rst_pc1",   32'(bus.id_pc1),   32'h0);
    model_reset();
    #11;
    rst = 1'b0;
    #1;
    check_model("rel");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h963C;
    mem[1] = 16'h920F;
    wbus.freeze    = 1'b0;
    wbus.br_taken  = 1'b0;
    wbus.br_target = 16'd0;
    wbus.id_ready  = 1'b1;

    do_reset();
    check_val("wrap_rst", 32'(wbus.pc_out), 32'hFFFF);

    // Boot cycle with a redirect that must be ignored
    step(1'b0, 1'b1, 16'h0055, 1'b1);
    check_val("boot_br_pc", 32'(bus.pc_out), 32'h0);
    check_val("boot_valid", 32'(bus.id_valid), 32'h0);
    check_val("wrap_boot", 32'(wbus.pc_out), 32'hFFFF);

    step(1'b0, 1'b0, 16'd0, 1'b1);
    check_val("t1_instr0", 32'(bus.id_instr), 32'h963C);
    check_val("t1_pc1_0",  32'(bus.id_pc1),   32'h1);
    check_val("wrap_pc",   32'(wbus.pc_out),  32'h0);
    step(1'b0, 1'b0, 16'd0, 1'b1);
    check_val("t1_instr1", 32'(bus.id_instr), 32'h920F);
    check_val("t1_pc1_1",  32'(bus.id_pc1),   32'h2);

    // Decode stalls: queue fills to two and PC stops
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'd0, 1'b0);

    // Redirect with a full queue, head not consumed
    step(1'b0, 1'b1, 16'd32, 1'b1);
    check_val("t3_valid", 32'(bus.id_valid), 32'h0);
    check_val("t3_pc",    32'(bus.pc_out),   32'd32);
    step(1'b0, 1'b0, 16'd0, 1'b0);
    check_val("t3_instr", 32'(bus.id_instr), 32'(mem[32]));
    check_val("t3_pc1",   32'(bus.id_pc1),   32'd33);

    // Freeze drains the queue with the PC held
    step(1'b0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'd0, 1'b1);
    check_val("t4_valid", 32'(bus.id_valid), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'd0, 1'b1);

    // Redirect and freeze together
    step(1'b1, 1'b1, 16'h0100, 1'b1);
    check_val("t5_pc", 32'(bus.pc_out), 32'h0100);
    step(1'b0, 1'b0, 16'd0, 1'b1);
    check_val("t5_frozen_pc", 32'(bus.pc_out), 32'h0100);
    step(1'b0, 1'b0, 16'd0, 1'b0);
    step(1'b0, 1'b0, 16'd0, 1'b0);

    // Async reset mid-stream with two entries queued
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'd0, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2;
        do_reset();
      end else begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
             16'($urandom), $urandom_range(0, 3) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
